// File: rtl/pll_freq_sequencer_if.sv
// rtl/pll_freq_sequencer_if.sv - request handshake and PLL reconfiguration controller signals
interface pll_freq_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_c;
  logic [7:0] pll_m;
  logic [7:0] pll_n;
  logic [7:0] pll_c;
  logic       trigger;
  logic       idle_state;
  logic       pll_locked;
  logic       done;
  logic [1:0] status;
  logic [7:0] current_c;

  modport master (
    output req_valid, req_c, idle_state, pll_locked,
    input  req_ready, pll_m, pll_n, pll_c, trigger, done, status, current_c
  );

  modport slave (
    input  req_valid, req_c, idle_state, pll_locked,
    output req_ready, pll_m, pll_n, pll_c, trigger, done, status, current_c
  );
endinterface

// File: rtl/pll_freq_sequencer.sv
// rtl/pll_freq_sequencer.sv - range-checks a post-divider request, drives one PLL reconfiguration, waits for stable lock
// Optional: define PLL_SEQ_RETRY_EN to re-trigger once after the first lock timeout of a request.
module pll_freq_sequencer #(
  parameter logic [7:0] PLL_M          = 8'd12,
  parameter logic [7:0] PLL_N          = 8'd1,
  parameter logic [7:0] C_MIN          = 8'd2,
  parameter logic [7:0] C_MAX          = 8'd255,
  parameter int         START_TIMEOUT  = 8,
  parameter int         RECONF_TIMEOUT = 256,
  parameter int         LOCK_TIMEOUT   = 4096,
  parameter int         SETTLE_CYCLES  = 16
) (
  input  logic                 clock_ctr,
  input  logic                 sys_reset,
  pll_freq_sequencer_if.slave  bus
);

  localparam int MAX_A = (LOCK_TIMEOUT > RECONF_TIMEOUT) ? LOCK_TIMEOUT : RECONF_TIMEOUT;
  localparam int MAX_B = (START_TIMEOUT > SETTLE_CYCLES) ? START_TIMEOUT : SETTLE_CYCLES;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] START_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] RECONF_LAST = CW'(RECONF_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_IDLE,
    WAIT_START,
    WAIT_DONE,
    WAIT_LOCK
  } state_t;

  state_t        state;
  logic [CW-1:0] timer;
  logic [CW-1:0] stable_cnt;
  logic [7:0]    pll_c_q;
  logic [7:0]    current_c_q;
  logic          req_ready_q;
  logic          trigger_q;
  logic          done_q;
  logic [1:0]    status_q;
`ifdef PLL_SEQ_RETRY_EN
  logic          retried;
`endif

  // Widened compare keeps the C_MAX bound meaningful even when it equals the 8-bit maximum.
  logic [8:0] c_ext;
  logic       c_out_of_range;
  assign c_ext          = {1'b0, pll_c_q};
  assign c_out_of_range = (c_ext < {1'b0, C_MIN}) || (c_ext > {1'b0, C_MAX});

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clock_ctr) begin
    if (sys_reset) begin
      state       <= IDLE;
      timer       <= '0;
      stable_cnt  <= '0;
      pll_c_q     <= 8'd0;
      current_c_q <= 8'd0;
      req_ready_q <= 1'b0;
      trigger_q   <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 2'b00;
`ifdef PLL_SEQ_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            pll_c_q     <= bus.req_c;
            req_ready_q <= 1'b0;
            state       <= CHECK;
`ifdef PLL_SEQ_RETRY_EN
            retried     <= 1'b0;
`endif
          end
        end
        CHECK: begin
          if (c_out_of_range) begin
            status_q    <= 2'b01;
            done_q      <= 1'b1;
            pll_c_q     <= current_c_q;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (bus.idle_state) begin
            trigger_q <= 1'b1;
            timer     <= '0;
            state     <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (!bus.idle_state) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timer == START_LAST) begin
            status_q    <= 2'b11;
            done_q      <= 1'b1;
            pll_c_q     <= current_c_q;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        WAIT_DONE: begin
          if (bus.idle_state) begin
            timer      <= '0;
            stable_cnt <= '0;
            state      <= WAIT_LOCK;
          end else if (timer == RECONF_LAST) begin
            status_q    <= 2'b11;
            done_q      <= 1'b1;
            pll_c_q     <= current_c_q;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        WAIT_LOCK: begin
          // Success is tested first so it wins when it lands on the timeout cycle.
          if (bus.pll_locked && (stable_cnt == SETTLE_LAST)) begin
            status_q    <= 2'b00;
            done_q      <= 1'b1;
            current_c_q <= pll_c_q;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end else if (timer == LOCK_LAST) begin
`ifdef PLL_SEQ_RETRY_EN
            if (!retried) begin
              retried <= 1'b1;
              state   <= WAIT_IDLE;
            end else begin
              status_q    <= 2'b10;
              done_q      <= 1'b1;
              pll_c_q     <= current_c_q;
              req_ready_q <= 1'b1;
              state       <= IDLE;
            end
`else
            status_q    <= 2'b10;
            done_q      <= 1'b1;
            pll_c_q     <= current_c_q;
            req_ready_q <= 1'b1;
            state       <= IDLE;
`endif
          end else begin
            timer      <= sat_inc(timer);
            stable_cnt <= bus.pll_locked ? sat_inc(stable_cnt) : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.pll_m     = PLL_M;
  assign bus.pll_n     = PLL_N;
  assign bus.pll_c     = pll_c_q;
  assign bus.trigger   = trigger_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.current_c = current_c_q;

endmodule

// File: tb/tb_pll_freq_sequencer.sv
// tb/tb_pll_freq_sequencer.sv - directed self-checking bench for pll_freq_sequencer with a reconfiguration controller model
module tb_pll_freq_sequencer;

  logic clock_ctr = 1'b0;
  logic sys_reset = 1'b1;

  pll_freq_sequencer_if bus ();

  pll_freq_sequencer dut (
    .clock_ctr (clock_ctr),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  always #5 clock_ctr = ~clock_ctr;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         trig_cnt = 0;
  int         trig_mark = 0;
  int         trig_cyc0 = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [1:0] done_status = 2'b00;
  logic       pll_c_watch = 1'b0;
  logic [7:0] watch_c = 8'd0;
  int         pll_c_bad = 0;
  int         ctl_mode = 0;
  int         ctl_cnt = -1;
  int         acc_cyc = 0;

  always @(posedge clock_ctr) cyc <= cyc + 1;

  always @(negedge clock_ctr) begin
    if (bus.trigger === 1'b1) begin
      if (trig_cnt == trig_mark) trig_cyc0 = cyc;
      trig_cnt = trig_cnt + 1;
    end
    if (bus.done === 1'b1) begin
      done_cnt    = done_cnt + 1;
      done_cyc    = cyc;
      done_status = bus.status;
    end
    if (pll_c_watch && (bus.pll_c !== watch_c)) pll_c_bad = pll_c_bad + 1;
  end

  // Controller model: mode 0 busy for 20 cycles starting one cycle after trigger,
  // mode 1 never leaves idle, mode 2 never returns to idle.
  initial begin
    bus.idle_state = 1'b1;
    forever begin
      @(posedge clock_ctr);
      #1;
      if (ctl_cnt >= 0) begin
        ctl_cnt = ctl_cnt + 1;
        if (ctl_cnt == 1 && ctl_mode != 1) bus.idle_state = 1'b0;
        if (ctl_cnt >= 21 && ctl_mode == 0) begin
          bus.idle_state = 1'b1;
          ctl_cnt = -1;
        end
      end
      if (bus.trigger === 1'b1) ctl_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_ctr);
    #1;
  endtask

  task automatic send_req(input logic [7:0] c);
    int k = 0;
    while (bus.req_ready !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    check("req_ready_before_send", 32'(bus.req_ready), 1);
    trig_mark     = trig_cnt;
    bus.req_c     = c;
    bus.req_valid = 1'b1;
    tick(1);
    acc_cyc       = cyc;
    bus.req_valid = 1'b0;
    check("pll_c_latched", 32'(bus.pll_c), 32'(c));
    check("req_ready_after_accept", 32'(bus.req_ready), 0);
  endtask

  task automatic wait_done(input int bound, input string tag);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < bound) begin
      tick(1);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt - d0), 1);
  endtask

  task automatic wait_ctl_cycle(input string tag);
    int k = 0;
    while (bus.idle_state !== 1'b0 && k < 100) begin
      @(negedge clock_ctr);
      k++;
    end
    while (bus.idle_state !== 1'b1 && k < 100) begin
      @(negedge clock_ctr);
      k++;
    end
    check({tag, "_ctl_cycle"}, 32'(k < 100), 1);
  endtask

  initial begin
    int d0;
    int rise_cyc;
    bus.req_valid  = 1'b0;
    bus.req_c      = 8'd0;
    bus.pll_locked = 1'b1;

    // Reset held for two cycles
    tick(1);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_trigger", 32'(bus.trigger), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_status", 32'(bus.status), 0);
    check("rst_pll_c", 32'(bus.pll_c), 0);
    check("rst_current_c", 32'(bus.current_c), 0);
    check("rst_pll_m", 32'(bus.pll_m), 12);
    check("rst_pll_n", 32'(bus.pll_n), 1);
    tick(1);
    sys_reset = 1'b0;
    check("rst_req_ready_at_release", 32'(bus.req_ready), 0);
    tick(1);
    check("req_ready_after_release", 32'(bus.req_ready), 1);

    // Happy path
    send_req(8'd10);
    watch_c     = 8'd10;
    pll_c_watch = 1'b1;
    wait_done(200, "happy");
    pll_c_watch = 1'b0;
    check("happy_status", 32'(done_status), 0);
    check("happy_triggers", 32'(trig_cnt - trig_mark), 1);
    check("happy_trig_to_done", 32'(done_cyc - trig_cyc0), 38);
    check("happy_accept_to_done", 32'(done_cyc - acc_cyc), 40);
    check("happy_current_c", 32'(bus.current_c), 10);
    check("happy_pll_c_stable", 32'(pll_c_bad), 0);
    d0 = done_cnt;
    tick(3);
    check("happy_single_done", 32'(done_cnt - d0), 0);

    // Range errors
    send_req(8'd1);
    wait_done(10, "range1");
    check("range1_status", 32'(done_status), 1);
    check("range1_latency", 32'(done_cyc - acc_cyc), 1);
    check("range1_triggers", 32'(trig_cnt - trig_mark), 0);
    check("range1_pll_c_revert", 32'(bus.pll_c), 10);
    check("range1_current_c", 32'(bus.current_c), 10);
    send_req(8'd0);
    wait_done(10, "range0");
    check("range0_status", 32'(done_status), 1);
    check("range0_latency", 32'(done_cyc - acc_cyc), 1);
    check("range0_triggers", 32'(trig_cnt - trig_mark), 0);
    check("range0_pll_c_revert", 32'(bus.pll_c), 10);

    // Lock glitch: 10 locked cycles in WAIT_LOCK, one low, then high
    send_req(8'd20);
    wait_ctl_cycle("glitch");
    repeat (11) @(posedge clock_ctr);
    #1;
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    rise_cyc = cyc;
    wait_done(60, "glitch");
    check("glitch_status", 32'(done_status), 0);
    check("glitch_rise_to_done", 32'(done_cyc - rise_cyc), 16);
    check("glitch_current_c", 32'(bus.current_c), 20);

    // Lock timeout
    bus.pll_locked = 1'b0;
    send_req(8'd30);
    wait_done(9000, "locktmo");
    check("locktmo_status", 32'(done_status), 2);
    check("locktmo_current_c", 32'(bus.current_c), 20);
`ifdef PLL_SEQ_RETRY_EN
    check("locktmo_triggers", 32'(trig_cnt - trig_mark), 2);
    check("locktmo_trig_to_done", 32'(done_cyc - trig_cyc0), 8237);
`else
    check("locktmo_triggers", 32'(trig_cnt - trig_mark), 1);
    check("locktmo_trig_to_done", 32'(done_cyc - trig_cyc0), 4118);
`endif
    bus.pll_locked = 1'b1;

    // Controller never leaves idle
    ctl_mode = 1;
    send_req(8'd40);
    wait_done(100, "stall_hi");
    check("stall_hi_status", 32'(done_status), 3);
    check("stall_hi_trig_to_done", 32'(done_cyc - trig_cyc0), 8);
    check("stall_hi_current_c", 32'(bus.current_c), 20);
    ctl_mode = 0;
    tick(2);
    send_req(8'd50);
    wait_done(200, "after_hi");
    check("after_hi_status", 32'(done_status), 0);
    check("after_hi_current_c", 32'(bus.current_c), 50);

    // Controller never returns to idle
    ctl_mode = 2;
    send_req(8'd60);
    wait_done(400, "stall_lo");
    check("stall_lo_status", 32'(done_status), 3);
    check("stall_lo_trig_to_done", 32'(done_cyc - trig_cyc0), 258);
    check("stall_lo_current_c", 32'(bus.current_c), 50);
    ctl_mode = 0;
    tick(2);
    send_req(8'd70);
    wait_done(200, "after_lo");
    check("after_lo_status", 32'(done_status), 0);
    check("after_lo_current_c", 32'(bus.current_c), 70);

    // Reset while waiting for lock
    bus.pll_locked = 1'b0;
    send_req(8'd80);
    wait_ctl_cycle("midrst");
    tick(5);
    d0 = done_cnt;
    sys_reset = 1'b1;
    tick(1);
    check("midrst_trigger", 32'(bus.trigger), 0);
    check("midrst_done", 32'(bus.done), 0);
    check("midrst_req_ready", 32'(bus.req_ready), 0);
    check("midrst_pll_c", 32'(bus.pll_c), 0);
    check("midrst_current_c", 32'(bus.current_c), 0);
    sys_reset = 1'b0;
    tick(3);
    check("midrst_no_done", 32'(done_cnt - d0), 0);
    check("midrst_idle_ready", 32'(bus.req_ready), 1);
    bus.pll_locked = 1'b1;
    send_req(8'd90);
    wait_done(200, "post_rst");
    check("post_rst_status", 32'(done_status), 0);
    check("post_rst_current_c", 32'(bus.current_c), 90);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
